// File: rtl/button_pkg.sv
// Shared definitions for the button event detector.
//   state_t : FSM state encoding (IDLE / PRESSED / HELD; 2'd3 is unreachable)
//   CNT_W   : width of the millisecond hold counter
package button_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

endpackage

// File: rtl/ms_tick.sv
// Millisecond prescaler: pulses tick for one cycle every MS_CYC clocks.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   clr   : synchronous restart; the next tick comes MS_CYC cycles later
//   tick  : high during the last cycle of each MS_CYC-cycle period
module ms_tick #(
  parameter int MS_CYC = 100_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(MS_CYC - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/button_event.sv
// Button event detector: turns a debounced button level into short-press,
// long-press and (optionally) auto-repeat pulses.
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-high
//   btn_clean    : debounced button level, 1 = pressed
//   pressed      : registered level, 1 while a press is in progress
//   short_press  : one-cycle pulse, released before LONG_MS
//   long_press   : one-cycle pulse, hold reached LONG_MS
//   repeat_pulse : one-cycle pulse every REPEAT_MS while held
// Build option: define BUTTON_EVENT_REPEAT_EN to compile in auto-repeat;
// without it repeat_pulse is tied low and REPEAT_MS has no effect.
module button_event
  import button_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_clean,
  output logic pressed,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int               MS_CYC    = CLK_HZ / 1000;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);

  // Elaboration-time parameter sanity checks.
  if (CLK_HZ < 1000 || (CLK_HZ % 1000) != 0) begin : g_bad_clk_hz
    $error("button_event: CLK_HZ must be a multiple of 1000 and >= 1000");
  end
  if (LONG_MS < 1 || LONG_MS > 65535) begin : g_bad_long_ms
    $error("button_event: LONG_MS must be 1..65535");
  end
  if (REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_bad_repeat_ms
    $error("button_event: REPEAT_MS must be 1..65535");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t           state, state_nx;
  logic [CNT_W-1:0] ms_cnt, ms_cnt_nx;
  logic             tick;
  logic             presc_clr;
  logic             short_nx, long_nx;

  // Restarting the prescaler on each phase entry makes the first ms of
  // every phase a full MS_CYC cycles long.
  ms_tick #(
    .MS_CYC (MS_CYC)
  ) u_ms_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (presc_clr),
    .tick  (tick)
  );

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_MS - 1);
  logic rep_nx;
`endif

  always_comb begin
    state_nx  = state;
    ms_cnt_nx = ms_cnt;
    presc_clr = 1'b0;
    short_nx  = 1'b0;
    long_nx   = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
    rep_nx    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (btn_clean) begin
          state_nx  = PRESSED;
          ms_cnt_nx = '0;
          presc_clr = 1'b1;
        end
      end
      PRESSED: begin
        // Release is checked first so it beats a coincident threshold tick.
        if (!btn_clean) begin
          state_nx = IDLE;
          short_nx = 1'b1;
        end else if (tick && ms_cnt == LONG_LAST) begin
          state_nx  = HELD;
          long_nx   = 1'b1;
          ms_cnt_nx = '0;
          presc_clr = 1'b1;
        end else if (tick) begin
          ms_cnt_nx = sat_inc(ms_cnt);
        end
      end
      HELD: begin
        if (!btn_clean) begin
          state_nx = IDLE;
`ifdef BUTTON_EVENT_REPEAT_EN
        end else if (tick && ms_cnt == REP_LAST) begin
          rep_nx    = 1'b1;
          ms_cnt_nx = '0;
`endif
        end else if (tick) begin
          ms_cnt_nx = sat_inc(ms_cnt);
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ms_cnt      <= '0;
      pressed     <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      state       <= state_nx;
      ms_cnt      <= ms_cnt_nx;
      pressed     <= (state_nx == PRESSED) || (state_nx == HELD);
      short_press <= short_nx;
      long_press  <= long_nx;
    end
  end

`ifdef BUTTON_EVENT_REPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= rep_nx;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule
